// File: rtl/sound_latch_fifo.sv
// 68K->Z80 sound command FIFO: edge-qualified latch strobes, registered
// Z80 read data, and a level IRQ while commands are pending.
module sound_latch_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m68k_latch_cs,
    input  logic [7:0]       m68k_din,
    input  logic             z80_latch_cs,
    input  logic             z80_latch_clr_cs,
    output logic [7:0]       z80_dout,
    output logic             z80_irq_n,
    output logic [PTR_W:0]   latch_count,
    output logic             latch_full,
    output logic             latch_overflow
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic             wr_cs_q, wr_cs_d;
    logic             rd_cs_q, rd_cs_d;
    logic             clr_cs_q, clr_cs_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       dout_q, dout_d;
    logic             irq_n_q, irq_n_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    logic push_ev, pop_ev, rd_ev;
    logic do_push, do_pop;
    logic not_empty;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // One bus cycle is one event no matter how long the strobe is held.
    always_comb begin
        wr_cs_d  = m68k_latch_cs;
        rd_cs_d  = z80_latch_cs;
        clr_cs_d = z80_latch_clr_cs;
        push_ev  = m68k_latch_cs & ~wr_cs_q;
        rd_ev    = z80_latch_cs & ~rd_cs_q;
        pop_ev   = z80_latch_clr_cs & ~clr_cs_q;
    end

    // A pop frees the slot a same-cycle push needs when the FIFO is full.
    always_comb begin
        not_empty = (count_q != '0);
        do_pop    = pop_ev & not_empty;
        do_push   = push_ev & ((count_q < DEPTH_C) | do_pop);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        ovf_d    = ovf_q | (push_ev & ~do_push);
        if (do_push) begin
            mem_d[wr_ptr_q] = m68k_din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            hold_d   = mem_q[rd_ptr_q];
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Reads sample the pre-update state; an empty FIFO returns the last pop.
    always_comb begin
        dout_d = dout_q;
        if (rd_ev) begin
            dout_d = not_empty ? mem_q[rd_ptr_q] : hold_q;
        end
        irq_n_d = ~not_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cs_q  <= 1'b0;
            rd_cs_q  <= 1'b0;
            clr_cs_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            hold_q   <= 8'h00;
            dout_q   <= 8'h00;
            irq_n_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_cs_q  <= wr_cs_d;
            rd_cs_q  <= rd_cs_d;
            clr_cs_q <= clr_cs_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            hold_q   <= hold_d;
            dout_q   <= dout_d;
            irq_n_q  <= irq_n_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign z80_dout       = dout_q;
    assign z80_irq_n      = irq_n_q;
    assign latch_count    = count_q;
    assign latch_full     = (count_q == DEPTH_C);
    assign latch_overflow = ovf_q;

endmodule

// File: tb/tb_sound_latch_fifo.sv
// Randomized bench for sound_latch_fifo against a queue-based model
// of the sound command path.
module tb_sound_latch_fifo;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             m68k_latch_cs;
    logic [7:0]       m68k_din;
    logic             z80_latch_cs;
    logic             z80_latch_clr_cs;
    logic [7:0]       z80_dout;
    logic             z80_irq_n;
    logic [PTR_W:0]   latch_count;
    logic             latch_full;
    logic             latch_overflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] m_hold;
    logic [7:0] m_dout;
    bit         m_ovf;

    sound_latch_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .m68k_latch_cs    (m68k_latch_cs),
        .m68k_din         (m68k_din),
        .z80_latch_cs     (z80_latch_cs),
        .z80_latch_clr_cs (z80_latch_clr_cs),
        .z80_dout         (z80_dout),
        .z80_irq_n        (z80_irq_n),
        .latch_count      (latch_count),
        .latch_full       (latch_full),
        .latch_overflow   (latch_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(latch_count), 32'(q.size()));
        chk({tag, "_full"}, 32'(latch_full), 32'(q.size() == DEPTH));
        chk({tag, "_ovf"}, 32'(latch_overflow), 32'(m_ovf));
        chk({tag, "_irq"}, 32'(z80_irq_n), 32'(q.size() == 0));
        chk({tag, "_dout"}, 32'(z80_dout), 32'(m_dout));
    endtask

    // One bus cycle: strobes held k clocks, then released for one clock.
    task automatic op(input bit w, input bit c, input bit r,
                      input logic [7:0] d, input int k, input string tag);
        m68k_din         = d;
        m68k_latch_cs    = w;
        z80_latch_clr_cs = c;
        z80_latch_cs     = r;
        repeat (k) step();
        m68k_latch_cs    = 1'b0;
        z80_latch_clr_cs = 1'b0;
        z80_latch_cs     = 1'b0;
        step();
        if (r) m_dout = (q.size() > 0) ? q[0] : m_hold;
        if (c && q.size() > 0) m_hold = q.pop_front();
        if (w) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end
        check_state(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        q.delete();
        m_hold = 8'h00;
        m_dout = 8'h00;
        m_ovf  = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        m68k_latch_cs    = 1'b0;
        m68k_din         = 8'h00;
        z80_latch_cs     = 1'b0;
        z80_latch_clr_cs = 1'b0;
        q.delete();
        m_hold = 8'h00;
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        repeat (3) step();
        check_state("rst");
        reset = 1'b0;
        step();

        op(0, 0, 1, 8'h00, 1, "t1_rd");
        chk("t1_rd00", 32'(z80_dout), 32'h00);

        op(1, 0, 0, 8'h5A, 1, "t2_wr");
        op(0, 0, 1, 8'h00, 2, "t2_rd");
        chk("t2_rd5a", 32'(z80_dout), 32'h5A);
        chk("t2_irq_on", 32'(z80_irq_n), 32'h0);
        z80_latch_clr_cs = 1'b1;
        step();
        chk("t2_clr_cnt", 32'(latch_count), 32'h0);
        chk("t2_irq_hold", 32'(z80_irq_n), 32'h0);
        z80_latch_clr_cs = 1'b0;
        step();
        chk("t2_irq_off", 32'(z80_irq_n), 32'h1);
        m_hold = q.pop_front();
        op(0, 0, 1, 8'h00, 1, "t2_rdh");
        chk("t2_hold5a", 32'(z80_dout), 32'h5A);

        for (int i = 1; i <= 4; i++) op(1, 0, 0, 8'(i), 1, "t3_wr");
        chk("t3_full", 32'(latch_full), 32'h1);
        op(1, 0, 0, 8'h05, 1, "t3_wr5");
        chk("t3_ovf", 32'(latch_overflow), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            op(0, 0, 1, 8'h00, 1, "t3_rd");
            chk("t3_order", 32'(z80_dout), 32'(i));
            op(0, 1, 0, 8'h00, 1, "t3_pop");
        end

        do_reset();
        op(1, 0, 0, 8'h33, 10, "t4_hold");
        chk("t4_one", 32'(latch_count), 32'h1);

        for (int i = 0; i < 3; i++) op(1, 0, 0, 8'hA0 + 8'(i), 1, "t5_fill");
        op(1, 1, 0, 8'h77, 1, "t5_both");
        chk("t5_cnt", 32'(latch_count), 32'h4);
        chk("t5_noovf", 32'(latch_overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            op(0, 0, 1, 8'h00, 1, "t5_rd");
            op(0, 1, 0, 8'h00, 1, "t5_pop");
        end
        chk("t5_last77", 32'(z80_dout), 32'h77);

        op(1, 0, 0, 8'h11, 1, "t6_wr");
        op(1, 0, 1, 8'h22, 1, "t6_wr");
        m68k_din      = 8'hAA;
        m68k_latch_cs = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        chk("t6_cnt0", 32'(latch_count), 32'h0);
        chk("t6_irq1", 32'(z80_irq_n), 32'h1);
        chk("t6_dout0", 32'(z80_dout), 32'h00);
        chk("t6_full0", 32'(latch_full), 32'h0);
        chk("t6_ovf0", 32'(latch_overflow), 32'h0);
        q.delete();
        m_hold = 8'h00;
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m68k_din = 8'hC3;
        step();
        reset = 1'b0;
        op(1, 0, 0, 8'hC3, 4, "t6_rel");
        chk("t6_one", 32'(latch_count), 32'h1);
        op(0, 0, 1, 8'h00, 1, "t6_rd");
        chk("t6_c3", 32'(z80_dout), 32'hC3);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            int kind;
            int k;
            kind = $urandom_range(0, 5);
            k    = $urandom_range(1, 3);
            case (kind)
                0, 1: op(1, 0, 0, 8'($urandom), k, "rnd_wr");
                2:    op(0, 1, 0, 8'h00, k, "rnd_pop");
                3:    op(0, 0, 1, 8'h00, k, "rnd_rd");
                4:    op(1, 1, 0, 8'($urandom), k, "rnd_wp");
                default: op(1, 1, 1, 8'($urandom), k, "rnd_all");
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
